// File: rtl/io_write_arbiter_pkg.sv
// io_write_arbiter_pkg: shared FSM state, source encoding and default widths for the IO write arbiter
package io_write_arbiter_pkg;
  localparam int AW_DEF = 13;
  localparam int DW_DEF = 13;
  localparam logic SRC_CORE = 1'b0;
  localparam logic SRC_HOST = 1'b1;
  typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/io_write_arbiter_if.sv
// io_write_arbiter_if: core write strobe, host request and shared IO bus signals of the arbiter
interface io_write_arbiter_if
  import io_write_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();
  logic          core_write;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wd;
  logic          host_valid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wd;
  logic          host_ready;
  logic          bus_valid;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wd;
  logic          bus_src;
  logic          bus_ready;
  modport slave (
    input  core_write, core_addr, core_wd, host_valid, host_addr, host_wd, bus_ready,
    output host_ready, bus_valid, bus_addr, bus_wd, bus_src
  );
  modport master (
    output core_write, core_addr, core_wd, host_valid, host_addr, host_wd, bus_ready,
    input  host_ready, bus_valid, bus_addr, bus_wd, bus_src
  );
endinterface

// File: rtl/io_write_fifo.sv
// io_write_fifo: core write queue; a push into a full queue only lands when a pop frees a slot that cycle
module io_write_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 26
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] level_q, level_d;
  logic [W-1:0] mem_q [DEPTH];
  logic push_ok, pop_ok;
  assign full = level_q == (PW+1)'(DEPTH);
  assign empty = level_q == '0;
  assign pop_ok = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  always_comb begin
    wr_d = wr_q + PW'(push_ok);
    rd_d = rd_q + PW'(pop_ok);
    level_d = level_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_q] <= wdata;
  end
  assign rdata = mem_q[rd_q];
  assign level = level_q;
endmodule

// File: rtl/io_write_arbiter.sv
// io_write_arbiter: round-robin arbitration of the core write FIFO and the host port (IO_ARB_HOST_EN) onto one IO bus
module io_write_arbiter
  import io_write_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  io_write_arbiter_if.slave      io,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic                   drained
);
  state_t state_q, state_d;
  logic last_src_q, last_src_d, bus_src_q, bus_src_d, overflow_q, overflow_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_wd_q, bus_wd_d;
  logic [AW+DW-1:0] head;
  logic host_req, full, empty, core_win, host_win;
`ifdef IO_ARB_HOST_EN
  assign host_req = io.host_valid;
`else
  logic unused_host;
  assign host_req = 1'b0;
  assign unused_host = ^{io.host_valid, io.host_addr, io.host_wd};
`endif
  io_write_fifo #(.DEPTH(DEPTH), .W(AW+DW)) u_fifo (
    .clock, .reset,
    .push(io.core_write), .pop(core_win),
    .wdata({io.core_addr, io.core_wd}), .rdata(head),
    .full, .empty, .level(fifo_level)
  );
  // On a conflict the source that was not granted last wins.
  assign core_win = state_q == IDLE && !empty && (!host_req || last_src_q == SRC_HOST);
  assign host_win = state_q == IDLE && host_req && (empty || last_src_q == SRC_CORE);
  always_comb begin
    state_d = state_q;
    last_src_d = last_src_q;
    bus_addr_d = bus_addr_q;
    bus_wd_d = bus_wd_q;
    bus_src_d = bus_src_q;
    overflow_d = overflow_q || (io.core_write && full && !core_win);
    if (core_win) begin
      {bus_addr_d, bus_wd_d} = head;
      bus_src_d = SRC_CORE;
      last_src_d = SRC_CORE;
      state_d = BUSY;
    end else if (host_win) begin
      bus_addr_d = io.host_addr;
      bus_wd_d = io.host_wd;
      bus_src_d = SRC_HOST;
      last_src_d = SRC_HOST;
      state_d = BUSY;
    end else if (state_q == BUSY && io.bus_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_src_q <= SRC_HOST;
      bus_addr_q <= '0;
      bus_wd_q <= '0;
      bus_src_q <= SRC_CORE;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_src_q <= last_src_d;
      bus_addr_q <= bus_addr_d;
      bus_wd_q <= bus_wd_d;
      bus_src_q <= bus_src_d;
      overflow_q <= overflow_d;
    end
  end
  assign io.bus_valid = state_q == BUSY;
  assign io.bus_addr = bus_addr_q;
  assign io.bus_wd = bus_wd_q;
  assign io.bus_src = bus_src_q;
  assign io.host_ready = host_win && !reset;
  assign overflow = overflow_q;
  assign drained = reset || (empty && state_q == IDLE && !host_req);
endmodule

// File: tb/tb_io_write_arbiter.sv
// tb_io_write_arbiter: queue-based reference model compared every cycle, plus directed literal checks
module tb_io_write_arbiter;
  localparam int AW = 13;
  localparam int DW = 13;
  localparam int DEPTH = 4;
`ifdef IO_ARB_HOST_EN
  localparam bit HOST_EN = 1'b1;
`else
  localparam bit HOST_EN = 1'b0;
`endif
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] w;} ent_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [$clog2(DEPTH):0] fifo_level;
  logic overflow, drained;
  io_write_arbiter_if #(.AW(AW), .DW(DW)) bus_if ();
  io_write_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .io(bus_if.slave),
    .fifo_level(fifo_level), .overflow(overflow), .drained(drained)
  );
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  ent_t cq[$];
  bit mbusy, msrc, mlast, movf;
  ent_t mbeat;
  logic [AW-1:0] dut_ret_a[$];
  bit dut_ret_s[$];
  int host_ready_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit host_wins();
    return HOST_EN && !reset && !mbusy && bus_if.host_valid && (cq.size() == 0 || !mlast);
  endfunction
  function automatic bit core_wins();
    return !mbusy && cq.size() > 0 && !host_wins();
  endfunction

  initial begin
    mbusy = 0; msrc = 0; mlast = 1; movf = 0; mbeat = '0;
    forever begin
      bit cw, hw, mfull;
      @(posedge clock or posedge reset);
      if (reset) begin
        cq.delete();
        mbusy = 0; mbeat = '0; msrc = 0; mlast = 1; movf = 0;
      end else begin
        cw = core_wins();
        hw = host_wins();
        mfull = cq.size() == DEPTH;
        if (mbusy) begin
          if (bus_if.bus_ready) mbusy = 0;
        end else if (cw) begin
          mbeat = cq.pop_front(); msrc = 0; mlast = 0; mbusy = 1;
        end else if (hw) begin
          mbeat = '{bus_if.host_addr, bus_if.host_wd}; msrc = 1; mlast = 1; mbusy = 1;
        end
        if (bus_if.core_write) begin
          if (mfull && !cw) movf = 1;
          else cq.push_back('{bus_if.core_addr, bus_if.core_wd});
        end
      end
    end
  end

  initial forever begin
    @(negedge clock);
    check("bus_valid", 32'(bus_if.bus_valid), 32'(mbusy));
    check("bus_addr", 32'(bus_if.bus_addr), 32'(mbeat.a));
    check("bus_wd", 32'(bus_if.bus_wd), 32'(mbeat.w));
    check("bus_src", 32'(bus_if.bus_src), 32'(msrc));
    check("host_ready", 32'(bus_if.host_ready), 32'(host_wins()));
    check("fifo_level", 32'(fifo_level), cq.size());
    check("overflow", 32'(overflow), 32'(movf));
    check("drained", 32'(drained),
          32'(reset || (cq.size() == 0 && !mbusy && !(HOST_EN && bus_if.host_valid))));
    if (bus_if.bus_valid && bus_if.bus_ready && !reset) begin
      dut_ret_a.push_back(bus_if.bus_addr);
      dut_ret_s.push_back(bus_if.bus_src);
    end
    if (bus_if.host_ready) host_ready_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic neg();
    @(negedge clock);
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] w);
    bus_if.core_write = 1; bus_if.core_addr = a; bus_if.core_wd = w;
    tick();
    bus_if.core_write = 0;
  endtask

  initial begin
    logic [AW-1:0] exp_ret [5];
    exp_ret = '{13'h20, 13'd1, 13'd2, 13'd3, 13'd4};
    bus_if.core_write = 0; bus_if.core_addr = 0; bus_if.core_wd = 0;
    bus_if.host_valid = 0; bus_if.host_addr = 0; bus_if.host_wd = 0;
    bus_if.bus_ready = 1;
    neg();
    check("rst_bus_valid", 32'(bus_if.bus_valid), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_drained", 32'(drained), 1);
    check("rst_bus_addr", 32'(bus_if.bus_addr), 0);
    check("rst_host_ready", 32'(bus_if.host_ready), 0);
    tick(); reset = 0; tick(); tick();
    // single core write: visible next cycle, on the bus the cycle after
    wr(13'd5, 13'd42);
    neg();
    check("lat_level", 32'(fifo_level), 1);
    check("lat_valid_early", 32'(bus_if.bus_valid), 0);
    tick(); neg();
    check("lat_valid", 32'(bus_if.bus_valid), 1);
    check("lat_addr", 32'(bus_if.bus_addr), 5);
    check("lat_wd", 32'(bus_if.bus_wd), 42);
    check("lat_src", 32'(bus_if.bus_src), 0);
    tick(); neg();
    check("lat_done_valid", 32'(bus_if.bus_valid), 0);
    check("lat_drained", 32'(drained), 1);
    tick();
    // stalled beat, then five writes: level saturates and the fifth drops
    bus_if.bus_ready = 0;
    wr(13'h20, 13'h120); tick();
    for (int i = 1; i <= 5; i++) wr(13'(i), 13'(100 + i));
    neg();
    check("ovf_level", 32'(fifo_level), 4);
    check("ovf_flag", 32'(overflow), 1);
    tick();
    dut_ret_a.delete(); dut_ret_s.delete();
    bus_if.bus_ready = 1;
    repeat (12) tick();
    neg();
    check("ret_count", dut_ret_a.size(), 5);
    for (int i = 0; i < 5 && i < dut_ret_a.size(); i++) check("ret_order", 32'(dut_ret_a[i]), 32'(exp_ret[i]));
    tick();
    // stall stability, then push and pop at full in the same cycle
    reset = 1; tick(); reset = 0; tick();
    bus_if.bus_ready = 0;
    wr(13'h30, 13'd7); tick();
    for (int i = 1; i <= 4; i++) wr(13'(13'h30 + i), 13'(i));
    repeat (7) begin
      neg();
      check("stall_addr", 32'(bus_if.bus_addr), 32'h30);
      check("stall_wd", 32'(bus_if.bus_wd), 7);
      check("stall_level", 32'(fifo_level), 4);
      check("stall_host_ready", 32'(bus_if.host_ready), 0);
    end
    tick();
    bus_if.bus_ready = 1; tick();
    bus_if.bus_ready = 0; wr(13'h3f, 13'd9);
    neg();
    check("full_pp_level", 32'(fifo_level), 4);
    check("full_pp_ovf", 32'(overflow), 0);
    check("full_pp_addr", 32'(bus_if.bus_addr), 32'h31);
    tick();
    // reset in the middle of a beat with three entries queued
    bus_if.bus_ready = 1; tick();
    bus_if.bus_ready = 0; tick();
    neg();
    check("pre_rst_level", 32'(fifo_level), 3);
    check("pre_rst_valid", 32'(bus_if.bus_valid), 1);
    #1 reset = 1;
    #1;
    check("mid_rst_valid", 32'(bus_if.bus_valid), 0);
    check("mid_rst_level", 32'(fifo_level), 0);
    check("mid_rst_ovf", 32'(overflow), 0);
    tick(); reset = 0; bus_if.bus_ready = 1; tick();
`ifdef IO_ARB_HOST_EN
    // persistent host and core requests alternate
    bus_if.bus_ready = 0;
    for (int i = 0; i < 4; i++) wr(13'(13'h40 + i), 13'(i));
    bus_if.host_valid = 1; bus_if.host_addr = 13'h77; bus_if.host_wd = 13'h5;
    dut_ret_a.delete(); dut_ret_s.delete();
    bus_if.bus_ready = 1;
    repeat (14) tick();
    neg();
    check("alt_count", 32'(dut_ret_s.size() >= 6), 1);
    for (int i = 0; i < 6 && i < dut_ret_s.size(); i++) check("alt_src", 32'(dut_ret_s[i]), 32'(i % 2));
    tick();
    bus_if.host_valid = 0; tick();
`endif
    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      reset = $urandom_range(199) == 0;
      bus_if.core_write = $urandom_range(2) == 0;
      bus_if.core_addr = 13'($urandom); bus_if.core_wd = 13'($urandom);
      bus_if.host_valid = $urandom_range(2) == 0;
      bus_if.host_addr = 13'($urandom); bus_if.host_wd = 13'($urandom);
      bus_if.bus_ready = $urandom_range(3) != 0;
      tick();
    end
    reset = 0; bus_if.core_write = 0; bus_if.host_valid = 0; bus_if.bus_ready = 1;
    repeat (20) tick();
    neg();
    check("end_drained", 32'(drained), 1);
`ifndef IO_ARB_HOST_EN
    check("host_ready_never", host_ready_cnt, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
